// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared constants, FSM state type and a one-hot helper for
//                the 4:1 mux round-robin select controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_sel_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux4_rr_sel_ctrl_if
//  Description : Request/ack, mux select/sample and downstream valid/ready
//                bundle of the round-robin select controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux4_rr_sel_ctrl_if;
    import mux_pkg::*;

    logic [NUM_CH-1:0] req;
    logic              mux_out;
    logic              out_ready;
    logic [SEL_W-1:0]  sel;
    logic              out_valid;
    logic              out_data;
    logic [SEL_W-1:0]  out_ch;
    logic [NUM_CH-1:0] ack;
    logic              busy;

    modport master (
        input  req, mux_out, out_ready,
        output sel, out_valid, out_data, out_ch, ack, busy
    );

    modport slave (
        output req, mux_out, out_ready,
        input  sel, out_valid, out_data, out_ch, ack, busy
    );

endinterface
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick4
//  Description : Combinational round-robin picker: first set req bit at or
//                above ptr, scanning upward modulo 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import mux_pkg::*;
(
    input  wire logic [NUM_CH-1:0] req,
    input  wire logic [SEL_W-1:0]  ptr,
    output logic      [SEL_W-1:0]  grant,
    output logic                   any
);

    logic [2*NUM_CH-1:0] w_dbl;
    logic [NUM_CH-1:0]   w_rot;
    logic [SEL_W-1:0]    w_idx;

    // Bit j of w_rot is req[(ptr + j) mod 4], so index 0 is the favoured channel.
    assign w_dbl = {req, req};
    assign w_rot = w_dbl[ptr +: NUM_CH];

    always_comb begin
        w_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_idx = SEL_W'(i);
            end
        end
    end

    assign grant = w_idx + ptr;
    assign any   = |req;

endmodule
`default_nettype wire

// File: rtl/mux4_rr_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mux4_rr_sel_ctrl
//  Description : Round-robin select controller for an external 4:1 mux; holds
//                sel for a settle window, samples mux_out, hands it downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_sel_ctrl
    import mux_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mux4_rr_sel_ctrl_if.master  bus
);

    localparam int                   C_CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [C_CNT_W-1:0]   C_CNT_LAST = C_CNT_W'(HOLD_CYCLES - 1);

    state_t              r_state;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_ptr;
    logic [SEL_W-1:0]    r_out_ch;
    logic                r_out_valid;
    logic                r_out_data;
    logic                r_busy;
    logic [NUM_CH-1:0]   r_ack;
    logic [C_CNT_W-1:0]  r_cnt;

    logic [SEL_W-1:0]    w_grant;
    logic                w_any;

    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (r_ptr),
        .grant (w_grant),
        .any   (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_ptr       <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 1'b0;
            r_busy      <= 1'b0;
            r_ack       <= '0;
            r_cnt       <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    // sel only ever moves here, keeping the mux glitch-free.
                    if (w_any) begin
                        r_sel   <= w_grant;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_CNT_LAST) begin
                        r_out_data  <= bus.mux_out;
                        r_out_ch    <= r_sel;
                        r_out_valid <= 1'b1;
                        r_ack       <= ch_onehot(r_sel);
                        r_ptr       <= r_sel + 1'b1;
                        r_state     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sel       = r_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.ack       = r_ack;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire
